// File: rtl/sseg_scan.sv
// Multiplexed common-anode seven-segment scanner with a double-buffered frame of glyph codes.
// Pending frames commit only at a frame-start tick, so a half-updated frame is never shown.
module sseg_scan #(
  parameter int unsigned NDIG    = 4,
  parameter int unsigned DIV     = 250000,
  parameter int unsigned BLINK_W = 6
) (
  input  logic              clk,
  input  logic              clr_n,
  input  logic              load,
  input  logic [5*NDIG-1:0] codes_in,
  input  logic [NDIG-1:0]   en_in,
  input  logic [NDIG-1:0]   blink_in,
  output logic [6:0]        seg,
  output logic [NDIG-1:0]   an,
  output logic              frame_sync,
  output logic              pending
);

  localparam int unsigned PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned IW = (NDIG > 1) ? $clog2(NDIG) : 1;

  logic [PW-1:0]      presc_q, presc_d;
  logic [IW-1:0]      idx_q, idx_d, idx_next;
  logic [BLINK_W-1:0] fcnt_q, fcnt_d;
  logic               tick, frame_start, phase;

  logic [5*NDIG-1:0]  act_codes_q, act_codes_d;
  logic [NDIG-1:0]    act_en_q, act_en_d;
  logic [NDIG-1:0]    act_blink_q, act_blink_d;
  logic [5*NDIG-1:0]  pend_codes_q, pend_codes_d;
  logic [NDIG-1:0]    pend_en_q, pend_en_d;
  logic [NDIG-1:0]    pend_blink_q, pend_blink_d;
  logic               pending_q, pending_d;

  logic [6:0]         seg_q, seg_d;
  logic [NDIG-1:0]    an_q, an_d;
  logic               frame_sync_q, frame_sync_d;

  logic [4:0]         code_sel;
  logic               en_sel, blink_sel;
  logic [NDIG-1:0]    an_sel;

  function automatic logic [6:0] glyph(input logic [4:0] code);
    logic [6:0] g;
    case (code)
      5'd0:    g = 7'h40;
      5'd1:    g = 7'h79;
      5'd2:    g = 7'h24;
      5'd3:    g = 7'h30;
      5'd4:    g = 7'h19;
      5'd5:    g = 7'h12;
      5'd6:    g = 7'h02;
      5'd7:    g = 7'h78;
      5'd8:    g = 7'h00;
      5'd9:    g = 7'h10;
      5'd10:   g = 7'h08;
      5'd11:   g = 7'h03;
      5'd12:   g = 7'h46;
      5'd13:   g = 7'h21;
      5'd14:   g = 7'h06;
      5'd15:   g = 7'h0E;
      5'd16:   g = 7'h41;
      5'd17:   g = 7'h47;
      5'd18:   g = 7'h0C;
      5'd19:   g = 7'h3F;
      default: g = 7'h7F;
    endcase
    return g;
  endfunction

  // Scan timing: prescaler, digit index and frame counter.
  always_comb begin
    tick        = (presc_q == PW'(DIV - 1));
    presc_d     = tick ? '0 : presc_q + PW'(1);
    idx_next    = (idx_q == IW'(NDIG - 1)) ? '0 : idx_q + IW'(1);
    frame_start = tick && (idx_next == '0);
    idx_d       = tick ? idx_next : idx_q;
    fcnt_d      = frame_start ? fcnt_q + BLINK_W'(1) : fcnt_q;
    phase       = fcnt_d[BLINK_W-1];
  end

  // Buffering: the commit uses the pending data from before any load on the same cycle.
  always_comb begin
    act_codes_d  = act_codes_q;
    act_en_d     = act_en_q;
    act_blink_d  = act_blink_q;
    pend_codes_d = pend_codes_q;
    pend_en_d    = pend_en_q;
    pend_blink_d = pend_blink_q;
    pending_d    = pending_q;
    if (frame_start && pending_q) begin
      act_codes_d = pend_codes_q;
      act_en_d    = pend_en_q;
      act_blink_d = pend_blink_q;
    end
    if (load) begin
      pend_codes_d = codes_in;
      pend_en_d    = en_in;
      pend_blink_d = blink_in;
      pending_d    = 1'b1;
    end else if (frame_start) begin
      pending_d    = 1'b0;
    end
  end

  // Select the digit about to be shown from the post-commit active buffer.
  always_comb begin
    code_sel  = 5'd31;
    en_sel    = 1'b0;
    blink_sel = 1'b0;
    an_sel    = '1;
    for (int unsigned k = 0; k < NDIG; k++) begin
      if (idx_next == IW'(k)) begin
        code_sel  = act_codes_d[5*k +: 5];
        en_sel    = act_en_d[k];
        blink_sel = act_blink_d[k];
        an_sel[k] = 1'b0;
      end
    end
  end

  always_comb begin
    seg_d        = seg_q;
    an_d         = an_q;
    frame_sync_d = frame_start;
    if (tick) begin
      if (!en_sel) begin
        seg_d = 7'h7F;
        an_d  = '1;
      end else if (blink_sel && phase) begin
        seg_d = 7'h7F;
        an_d  = an_sel;
      end else begin
        seg_d = glyph(code_sel);
        an_d  = an_sel;
      end
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      presc_q      <= '0;
      idx_q        <= IW'(NDIG - 1);
      fcnt_q       <= '0;
      act_codes_q  <= '1;
      act_en_q     <= '0;
      act_blink_q  <= '0;
      pend_codes_q <= '0;
      pend_en_q    <= '0;
      pend_blink_q <= '0;
      pending_q    <= 1'b0;
      seg_q        <= 7'h7F;
      an_q         <= '1;
      frame_sync_q <= 1'b0;
    end else begin
      presc_q      <= presc_d;
      idx_q        <= idx_d;
      fcnt_q       <= fcnt_d;
      act_codes_q  <= act_codes_d;
      act_en_q     <= act_en_d;
      act_blink_q  <= act_blink_d;
      pend_codes_q <= pend_codes_d;
      pend_en_q    <= pend_en_d;
      pend_blink_q <= pend_blink_d;
      pending_q    <= pending_d;
      seg_q        <= seg_d;
      an_q         <= an_d;
      frame_sync_q <= frame_sync_d;
    end
  end

  assign seg        = seg_q;
  assign an         = an_q;
  assign frame_sync = frame_sync_q;
  assign pending    = pending_q;

endmodule
